// File: rtl/measure_pkg.sv
// measure_pkg: shared mode encodings, FSM states and timing constants for measure_engine.
package measure_pkg;

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_TIME   = 3'd1;
    localparam logic [2:0] MODE_VOLT   = 3'd2;
    localparam logic [2:0] MODE_RAW_DX = 3'd3;
    localparam logic [2:0] MODE_RAW_DY = 3'd4;

    typedef enum logic [2:0] {IDLE, CAPTURE, MULT, CLAMP, BCD, DONE} state_t;

    function automatic int maxDisplay(input int digits);
        int m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        return m - 1;
    endfunction

    function automatic int latency(input int scaleW, input int resultW);
        return scaleW + resultW + 4;
    endfunction

    localparam int MAX_DISPLAY = maxDisplay(4);
    localparam int LAT = latency(6, 14);

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle; done marks the final shift cycle.
module bin2bcd_seq #(
    parameter int RESULT_W   = 14,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [RESULT_W-1:0]     bin,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(RESULT_W + 1);

    logic [RESULT_W-1:0]     sr;
    logic [CNT_W-1:0]        cnt;
    logic [4*BCD_DIGITS-1:0] adj;

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_dig
        assign adj[4*d +: 4] = bcd[4*d +: 4] > 4'd4 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    end

    // high during the cycle whose closing edge performs the last shift
    assign done = cnt == CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
            bcd <= '0;
        end else if (load) begin
            sr  <= bin;
            bcd <= '0;
            cnt <= CNT_W'(RESULT_W);
        end else if (cnt != '0) begin
            bcd <= {adj[4*BCD_DIGITS-2:0], sr[RESULT_W-1]};
            sr  <= sr << 1;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/measure_engine.sv
// measure_engine: cursor delta x per-channel factor, clamped to display range, as binary and packed BCD.
module measure_engine import measure_pkg::*; #(
    parameter int NUM_CH     = 4,
    parameter int COORD_W    = 11,
    parameter int SCALE_W    = 6,
    parameter int BCD_DIGITS = 4,
    parameter int RESULT_W   = 14,
    localparam int SEL_W     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [COORD_W-1:0]        cursorX1,
    input  logic [COORD_W-1:0]        cursorX2,
    input  logic [COORD_W-1:0]        cursorY1,
    input  logic [COORD_W-1:0]        cursorY2,
    input  logic [NUM_CH*SCALE_W-1:0] sampleAdjust,
    input  logic [NUM_CH*4-1:0]       shiftDown,
    input  logic [SEL_W-1:0]          waveSel,
    input  logic [2:0]                measurement,
    output logic                      busy,
    output logic                      valid,
    output logic [RESULT_W-1:0]       result,
    output logic [4*BCD_DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int FACT_W  = SCALE_W + 1;
    localparam int PROD_W  = COORD_W + SCALE_W + 1;
    localparam int CNT_W   = $clog2(FACT_W + 1);
    localparam int MAX_DSP = maxDisplay(BCD_DIGITS);

    state_t state, nextState;

    logic [COORD_W-1:0]      x1, x2, y1, y2, dx, dy;
    logic [2:0]              mode;
    logic [SCALE_W-1:0]      adj;
    logic [3:0]              sd;
    logic [SEL_W-1:0]        chan;
    logic [FACT_W-1:0]       fac, factor;
    logic [PROD_W-1:0]       mcand, acc;
    logic [CNT_W-1:0]        cnt;
    logic [RESULT_W-1:0]     value, clampVal;
    logic                    ovf, isOver, useY, bcdLoad, bcdDone;
    logic [4*BCD_DIGITS-1:0] bcdOut;

    assign chan     = 32'(waveSel) < NUM_CH ? waveSel : '0;
    assign dx       = x1 >= x2 ? x1 - x2 : x2 - x1;
    assign dy       = y1 >= y2 ? y1 - y2 : y2 - y1;
    assign useY     = mode == MODE_VOLT || mode == MODE_RAW_DY;
    assign fac      = mode == MODE_TIME ? FACT_W'(adj) + FACT_W'(1) :
                      mode == MODE_VOLT ? FACT_W'(sd) + FACT_W'(1) :
                      (mode == MODE_RAW_DX || mode == MODE_RAW_DY) ? FACT_W'(1) : '0;
    assign isOver   = acc > PROD_W'(MAX_DSP);
    assign clampVal = isOver ? RESULT_W'(MAX_DSP) : RESULT_W'(acc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        bcdLoad   = 1'b0;
        unique case (state)
            IDLE:    nextState = start ? CAPTURE : IDLE;
            CAPTURE: nextState = MULT;
            MULT:    nextState = cnt == CNT_W'(SCALE_W) ? CLAMP : MULT;
            CLAMP: begin
                nextState = BCD;
                bcdLoad   = 1'b1;
            end
            BCD:     nextState = bcdDone ? DONE : BCD;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {x1, x2, y1, y2, mode, adj, sd} <= '0;
            {mcand, factor, acc, cnt, value, ovf} <= '0;
            {busy, valid, result, bcd, overflow} <= '0;
        end else begin
            busy  <= nextState != IDLE;
            valid <= state == DONE;
            if (state == IDLE && start) begin
                x1   <= cursorX1;
                x2   <= cursorX2;
                y1   <= cursorY1;
                y2   <= cursorY2;
                mode <= measurement;
                adj  <= sampleAdjust[chan*SCALE_W +: SCALE_W];
                sd   <= shiftDown[chan*4 +: 4];
            end else if (state == CAPTURE) begin
                mcand  <= PROD_W'(useY ? dy : dx);
                factor <= fac;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MULT) begin
                acc    <= acc + (factor[0] ? mcand : '0);
                mcand  <= mcand << 1;
                factor <= factor >> 1;
                cnt    <= cnt + 1'b1;
            end else if (state == CLAMP) begin
                value <= clampVal;
                ovf   <= isOver;
            end else if (state == DONE) begin
                result   <= value;
                bcd      <= bcdOut;
                overflow <= ovf;
            end
        end
    end

    bin2bcd_seq #(.RESULT_W(RESULT_W), .BCD_DIGITS(BCD_DIGITS)) u_bcd (
        .clock (clock),
        .reset (reset),
        .load  (bcdLoad),
        .bin   (clampVal),
        .done  (bcdDone),
        .bcd   (bcdOut)
    );

endmodule

// File: tb/tb_measure_engine.sv
// tb_measure_engine: directed-vector bench for measure_engine with immediate-assertion checks.
module tb_measure_engine;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [10:0] cursorX1, cursorX2, cursorY1, cursorY2;
    logic [23:0] sampleAdjust;
    logic [15:0] shiftDown;
    logic [1:0]  waveSel;
    logic [2:0]  measurement;
    logic        busy, valid, overflow;
    logic [13:0] result;
    logic [15:0] bcd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    measure_engine dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .cursorX1     (cursorX1),
        .cursorX2     (cursorX2),
        .cursorY1     (cursorY1),
        .cursorY2     (cursorY2),
        .sampleAdjust (sampleAdjust),
        .shiftDown    (shiftDown),
        .waveSel      (waveSel),
        .measurement  (measurement),
        .busy         (busy),
        .valid        (valid),
        .result       (result),
        .bcd          (bcd),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setInputs(input logic [2:0] mode, input logic [1:0] sel,
                             input logic [10:0] x1, input logic [10:0] x2,
                             input logic [10:0] y1, input logic [10:0] y2);
        measurement = mode;
        waveSel     = sel;
        cursorX1    = x1;
        cursorX2    = x2;
        cursorY1    = y1;
        cursorY2    = y2;
    endtask

    task automatic measure(input string tag, input logic [2:0] mode, input logic [1:0] sel,
                           input logic [10:0] x1, input logic [10:0] x2,
                           input logic [10:0] y1, input logic [10:0] y2,
                           input logic [13:0] expRes, input logic [15:0] expBcd, input logic expOvf);
        int lat = -1;
        setInputs(mode, sel, x1, x2, y1, y2);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, ".busy_on"}, 32'(busy), 1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (valid) begin
                lat = k;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 24);
        check({tag, ".result"}, 32'(result), 32'(expRes));
        check({tag, ".bcd"}, 32'(bcd), 32'(expBcd));
        check({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
        check({tag, ".busy_off"}, 32'(busy), 0);
        @(negedge clock);
        check({tag, ".valid_pulse"}, 32'(valid), 0);
        check({tag, ".result_hold"}, 32'(result), 32'(expRes));
    endtask

    initial begin
        int nv, v1, v2;
        reset        = 1'b1;
        start        = 1'b0;
        sampleAdjust = {6'd9, 6'd4, 6'd17, 6'd33};
        shiftDown    = {4'd7, 4'd5, 4'd3, 4'd11};
        setInputs(3'd0, 2'd0, 11'd0, 11'd0, 11'd0, 11'd0);
        repeat (3) @(negedge clock);
        check("rst.busy", 32'(busy), 0);
        check("rst.valid", 32'(valid), 0);
        check("rst.result", 32'(result), 0);
        check("rst.bcd", 32'(bcd), 0);
        check("rst.overflow", 32'(overflow), 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("idle.busy", 32'(busy), 0);
        check("idle.valid", 32'(valid), 0);
        check("idle.result", 32'(result), 0);

        measure("time", 3'd1, 2'd2, 11'd100, 11'd40, 11'd0, 11'd0, 14'd300, 16'h0300, 1'b0);
        measure("volt", 3'd2, 2'd1, 11'd0, 11'd0, 11'd10, 11'd250, 14'd960, 16'h0960, 1'b0);
        measure("volt_ch3", 3'd2, 2'd3, 11'd0, 11'd0, 11'd300, 11'd200, 14'd800, 16'h0800, 1'b0);
        sampleAdjust[5:0] = 6'd63;
        measure("clamp", 3'd1, 2'd0, 11'd2000, 11'd0, 11'd0, 11'd0, 14'd9999, 16'h9999, 1'b1);
        measure("rawdx0", 3'd3, 2'd0, 11'd5, 11'd5, 11'd0, 11'd0, 14'd0, 16'h0000, 1'b0);
        measure("rawdy", 3'd4, 2'd3, 11'd0, 11'd0, 11'd3, 11'd1234, 14'd1231, 16'h1231, 1'b0);
        measure("off", 3'd0, 2'd2, 11'd100, 11'd40, 11'd7, 11'd9, 14'd0, 16'h0000, 1'b0);

        // inputs and start toggled while busy must not disturb the captured job
        setInputs(3'd3, 2'd0, 11'd700, 11'd200, 11'd0, 11'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        nv = 0;
        v1 = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (valid) begin
                nv++;
                if (v1 < 0) v1 = k;
            end
            if (k == 2) setInputs(3'd4, 2'd1, 11'd1000, 11'd0, 11'd50, 11'd0);
            start = (k == 3 || k == 10 || k == 20);
        end
        start = 1'b0;
        check("busy_ign.count", 32'(nv), 1);
        check("busy_ign.latency", 32'(v1), 24);
        check("busy_ign.result", 32'(result), 500);
        check("busy_ign.bcd", 32'(bcd), 32'h0500);

        measure("mode6", 3'd6, 2'd2, 11'd100, 11'd40, 11'd10, 11'd250, 14'd0, 16'h0000, 1'b0);

        // start held high retriggers on the idle cycle after the valid pulse
        setInputs(3'd3, 2'd0, 11'd30, 11'd10, 11'd0, 11'd0);
        start = 1'b1;
        @(negedge clock);
        nv = 0;
        v1 = -1;
        v2 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (valid) begin
                nv++;
                if (v1 < 0) v1 = k;
                else v2 = k;
            end
            if (k == 25) start = 1'b0;
        end
        check("retrig.count", 32'(nv), 2);
        check("retrig.first", 32'(v1), 24);
        check("retrig.second", 32'(v2), 49);
        check("retrig.result", 32'(result), 20);

        // reset in flight aborts without a valid pulse
        setInputs(3'd1, 2'd2, 11'd100, 11'd40, 11'd0, 11'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 0);
        check("abort.valid", 32'(valid), 0);
        check("abort.result", 32'(result), 0);
        check("abort.bcd", 32'(bcd), 0);
        check("abort.overflow", 32'(overflow), 0);
        @(negedge clock);
        reset = 1'b0;
        nv = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (valid) nv++;
        end
        check("abort.no_valid", 32'(nv), 0);
        measure("after_rst", 3'd2, 2'd1, 11'd0, 11'd0, 11'd10, 11'd250, 14'd960, 16'h0960, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/measure_engine.md
Name: measure_engine

Overview:
- Multi-channel cursor measurement engine for the scope display path; successor to the single-mode cursor measure block.
- On a start pulse it captures both cursor pairs and the selected channel's sample-rate and shrink settings.
- It forms a true absolute cursor delta, scales it with a sequential shift-add multiplier, clamps it to the display range, and converts it to packed BCD with a sequential double-dabble.
- Output feeds the 7-segment/overlay readout, with a busy/valid handshake.

Parameters:
- NUM_CH, 4: number of wave channels; waveSel width is clog2(NUM_CH), minimum 1.
- COORD_W, 11: cursor coordinate width.
- SCALE_W, 6: per-channel sample-adjust width; shift-down width is fixed at 4.
- BCD_DIGITS, 4: display digits; MAX_DISPLAY = 10^BCD_DIGITS - 1.
- RESULT_W, 14: binary result width; must satisfy 2^RESULT_W > MAX_DISPLAY.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- cursorX1  in  COORD_W  cursor x1.
- cursorX2  in  COORD_W  cursor x2.
- cursorY1  in  COORD_W  cursor y1.
- cursorY2  in  COORD_W  cursor y2.
- sampleAdjust  in  NUM_CH*SCALE_W  per-channel sample rate; channel n occupies slice n.
- shiftDown  in  NUM_CH*4  per-channel shrink value.
- waveSel  in  clog2(NUM_CH)  channel to measure.
- measurement  in  3  mode select.
- busy  out  1  high from the cycle after start is accepted until valid.
- valid  out  1  one-cycle pulse; result, bcd and overflow are new in that cycle.
- result  out  RESULT_W  clamped scaled value.
- bcd  out  4*BCD_DIGITS  packed BCD of result, most significant digit at the top.
- overflow  out  1  product exceeded MAX_DISPLAY.

Behaviour:
- Reset, asynchronous, active-high:
  - State goes to IDLE.
  - busy, valid, result, bcd and overflow all go to 0.
  - Any measurement in flight is aborted with no valid pulse.
- Modes:
  - 0 off: factor 0.
  - 1 time: |X1-X2| * (sampleAdjust[waveSel]+1).
  - 2 volts: |Y1-Y2| * (shiftDown[waveSel]+1).
  - 3 raw dx: |X1-X2| * 1.
  - 4 raw dy: |Y1-Y2| * 1.
  - 5-7: treated as mode 0, result 0.
- Absolute delta: compare first, then subtract larger minus smaller. No signed-wrap tricks; result is COORD_W bits, unsigned.
- Factor width is SCALE_W+1. Product width is COORD_W+SCALE_W+1.
- FSM:
  - IDLE: on start=1, register all inputs, move to CAPTURE, set busy=1.
  - CAPTURE, 1 cycle: compute delta and factor.
  - MULT, SCALE_W+1 cycles: shift-add, one factor bit per cycle, LSB first.
  - CLAMP, 1 cycle: if product > MAX_DISPLAY, value = MAX_DISPLAY and overflow = 1; else value = product and overflow = 0.
  - BCD, RESULT_W cycles: double-dabble, one bit per cycle.
  - DONE, 1 cycle: update result, bcd and overflow; valid=1; busy=0; return to IDLE.
- Latency is fixed at LAT = SCALE_W + RESULT_W + 4 (24 with defaults). The valid pulse begins LAT edges after the edge that accepted start, independent of mode or operand values.
- Inputs are sampled once, at acceptance. Later input changes do not affect the measurement in flight.
- start while busy is ignored, not queued. start held high retriggers at the first IDLE cycle after DONE.
- result, bcd and overflow hold their values between valid pulses.
- waveSel >= NUM_CH (non-power-of-2 NUM_CH) selects channel 0.

Decomposition:
- Shared package measure_pkg:
  - Mode encodings: MODE_OFF, MODE_TIME, MODE_VOLT, MODE_RAW_DX, MODE_RAW_DY.
  - FSM state typedef.
  - LAT, and MAX_DISPLAY as a function of BCD_DIGITS.
- One sub-module, bin2bcd_seq:
  - Sequential double-dabble, parametrised by RESULT_W and BCD_DIGITS.
  - Handshake: load/done; done fires exactly RESULT_W cycles after load.
  - The measure_engine FSM waits on its done.

Test Plan:
1. Reset mid-idle -> busy, valid, result, bcd and overflow all 0. Release reset, no start -> outputs stay 0.
2. Mode 1, waveSel=2, sampleAdjust[2]=4, X1=100, X2=40, start 1 cycle -> valid exactly 24 cycles later; result=300, bcd=0x0300, overflow=0.
3. Mode 2, waveSel=1, shiftDown[1]=3, Y1=10, Y2=250 (reversed cursors) -> result=960, bcd=0x0960; no negative wrap.
4. Mode 1, X1=2000, X2=0, sampleAdjust=63 (product 128000) -> result=9999, bcd=0x9999, overflow=1. Next mode 3 with X1=5, X2=5 -> result=0, overflow=0.
5. Inputs change and start pulses during busy -> single valid with the originally captured values. Mode 6 -> result=0, same 24-cycle latency.
6. Assert reset 10 cycles after start -> no valid, busy=0, outputs 0. A new start after reset -> correct result at LAT.
